// File: rtl/mips32_mem_responder_if.sv
// Fetch and data request/response bus between a MIPS32 core and its memory responder.
interface mips32_mem_responder_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output if_ack, if_rdata, d_ack, d_rdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  if_ack, if_rdata, d_ack, d_rdata, busy
    );
endinterface

// File: rtl/mips32_mem_responder.sv
// Single-ported word memory shared by fetch and data ports, with fixed wait states
// and data-priority arbitration that lets fetch through after two straight losses.
module mips32_mem_responder #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mips32_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WC = 4'(WAIT_CYC);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [1:0]        loss_q;
    logic              gnt_d_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              if_ack_q, d_ack_q, busy_q;
    logic [31:0]       if_rdata_q, d_rdata_q;

    logic [31:0] mem [2**ADDR_W];

    logic take_d;
    logic do_acc;

    assign take_d = bus.d_req && (!bus.if_req || loss_q != 2'd2);
    // With no wait states there is no WAIT edge, so the access lands on the RESP edge.
    assign do_acc = (state_q == WAIT && cnt_q == 4'd1) ||
                    (state_q == RESP && WC == 4'd0);

    always_ff @(posedge clk) begin
        if (do_acc && we_q) mem[addr_q] <= wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            loss_q     <= '0;
            gnt_d_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            busy_q     <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            if (do_acc && !we_q) begin
                if (gnt_d_q) d_rdata_q  <= mem[addr_q];
                else         if_rdata_q <= mem[addr_q];
            end
            case (state_q)
                IDLE: begin
                    if (bus.d_req || bus.if_req) begin
                        gnt_d_q <= take_d;
                        addr_q  <= take_d ? bus.d_addr : bus.if_addr;
                        we_q    <= take_d & bus.d_we;
                        wdata_q <= bus.d_wdata;
                        if (!take_d)        loss_q <= 2'd0;
                        else if (bus.if_req) loss_q <= loss_q + 2'd1;
                        cnt_q   <= WC;
                        state_q <= (WC == 4'd0) ? RESP : WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= RESP;
                end
                RESP: begin
                    if (gnt_d_q) d_ack_q  <= 1'b1;
                    else         if_ack_q <= 1'b1;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_ack   = if_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.busy     = busy_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
endmodule

// File: tb/tb_mips32_mem_responder.sv
// Scenario bench for the memory responder: one instance with two wait states, one with none.
module tb_mips32_mem_responder;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [31:0] exp_drd, exp_ird;
    logic [31:0] rd;
    int          lat, bc;

    mips32_mem_responder_if #(.ADDR_W(10)) b2 ();
    mips32_mem_responder_if #(.ADDR_W(10)) b0 ();

    mips32_mem_responder #(.ADDR_W(10), .WAIT_CYC(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    mips32_mem_responder #(.ADDR_W(10), .WAIT_CYC(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    // One complete handshake on the two-wait-state instance; lat counts sampled edges to ack.
    task automatic op2(input bit fetch, input bit we, input logic [9:0] a, input logic [31:0] wd,
                       output logic [31:0] r, output int l, output int b);
        @(posedge clk); #1;
        if (fetch) begin
            b2.if_req = 1'b1; b2.if_addr = a;
        end else begin
            b2.d_req = 1'b1; b2.d_we = we; b2.d_addr = a; b2.d_wdata = wd;
        end
        l = 0; b = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            l++;
            if (fetch ? b2.if_ack : b2.d_ack) break;
            if (b2.busy) b++;
        end
        b2.if_req = 1'b0; b2.d_req = 1'b0;
        r = fetch ? b2.if_rdata : b2.d_rdata;
    endtask

    task automatic op0(input bit we, input logic [9:0] a, input logic [31:0] wd,
                       output logic [31:0] r, output int l);
        @(posedge clk); #1;
        b0.d_req = 1'b1; b0.d_we = we; b0.d_addr = a; b0.d_wdata = wd;
        l = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            l++;
            if (b0.d_ack) break;
        end
        b0.d_req = 1'b0;
        r = b0.d_rdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({b2.if_ack, b2.d_ack, b2.busy, b2.if_rdata, b2.d_rdata} !== 67'd0) begin
            fails++;
            $display("FAIL reset_outputs_w2: got %h want 0", {b2.if_ack, b2.d_ack, b2.busy, b2.if_rdata, b2.d_rdata});
        end
        tests++;
        if ({b0.if_ack, b0.d_ack, b0.busy, b0.if_rdata, b0.d_rdata} !== 67'd0) begin
            fails++;
            $display("FAIL reset_outputs_w0: got %h want 0", {b0.if_ack, b0.d_ack, b0.busy, b0.if_rdata, b0.d_rdata});
        end
        rst_n = 1'b1;
        exp_drd = 32'd0; exp_ird = 32'd0;
    endtask

    task automatic test_basic();
        op2(1'b0, 1'b1, 10'd5, 32'h0000_00AA, rd, lat, bc);
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL basic_store_lat: got %0d want 4", lat); end
        tests++;
        if (bc !== 3) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 3", bc); end
        tests++;
        if (rd !== exp_drd) begin fails++; $display("FAIL basic_store_drdata: got %h want %h", rd, exp_drd); end
        op2(1'b1, 1'b0, 10'd5, 32'd0, rd, lat, bc);
        exp_ird = 32'h0000_00AA;
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL basic_fetch_lat: got %0d want 4", lat); end
        tests++;
        if (rd !== exp_ird) begin fails++; $display("FAIL basic_fetch_data: got %h want %h", rd, exp_ird); end
    endtask

    task automatic test_arbitration();
        logic [5:0] got;
        int n, last, cyc;
        bit both, gap_bad;
        got = '0; n = 0; last = 0; cyc = 0; both = 0; gap_bad = 0;
        @(posedge clk); #1;
        b2.d_we = 1'b0; b2.d_addr = 10'd5; b2.if_addr = 10'd5;
        b2.d_req = 1'b1; b2.if_req = 1'b1;
        for (int k = 0; k < 80 && n < 6; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (b2.d_ack && b2.if_ack) both = 1;
            if (b2.d_ack || b2.if_ack) begin
                got = {got[4:0], b2.d_ack};
                if (n > 0 && cyc - last != 4) gap_bad = 1;
                last = cyc;
                n++;
            end
        end
        b2.d_req = 1'b0; b2.if_req = 1'b0;
        exp_drd = 32'h0000_00AA;
        tests++;
        if (n !== 6 || got !== 6'b110110) begin
            fails++; $display("FAIL arb_order: got %b (%0d acks) want 110110 (D=1)", got, n);
        end
        tests++;
        if (both !== 1'b0) begin fails++; $display("FAIL arb_dual_ack: got both acks high, want exclusive"); end
        tests++;
        if (gap_bad !== 1'b0) begin fails++; $display("FAIL arb_throughput: got gap != 4, want 4"); end
        tests++;
        if (b2.d_rdata !== exp_drd) begin fails++; $display("FAIL arb_drdata: got %h want %h", b2.d_rdata, exp_drd); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_midwait_change();
        logic [31:0] va, vb;
        int l;
        va = $urandom; vb = ~va;
        op2(1'b0, 1'b1, 10'd8, va, rd, lat, bc);
        op2(1'b0, 1'b1, 10'd9, vb, rd, lat, bc);
        @(posedge clk); #1;
        b2.d_req = 1'b1; b2.d_we = 1'b0; b2.d_addr = 10'd8;
        @(posedge clk); #1;
        l = 1;
        b2.d_req = 1'b0; b2.d_addr = 10'd9;
        for (int k = 0; k < 20; k++) begin
            if (b2.d_ack) break;
            @(posedge clk); #1;
            l++;
        end
        exp_drd = va;
        tests++;
        if (l !== 4) begin fails++; $display("FAIL midwait_ack_lat: got %0d want 4", l); end
        tests++;
        if (b2.d_rdata !== exp_drd) begin fails++; $display("FAIL midwait_data: got %h want %h", b2.d_rdata, exp_drd); end
        op2(1'b0, 1'b1, 10'd3, $urandom, rd, lat, bc);
        tests++;
        if (rd !== exp_drd) begin fails++; $display("FAIL store_keeps_drdata: got %h want %h", rd, exp_drd); end
    endtask

    task automatic test_reset_abort();
        int acks;
        op2(1'b0, 1'b1, 10'd7, 32'h1234_5678, rd, lat, bc);
        @(posedge clk); #1;
        b2.d_req = 1'b1; b2.d_we = 1'b1; b2.d_addr = 10'd7; b2.d_wdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({b2.if_ack, b2.d_ack, b2.busy, b2.if_rdata, b2.d_rdata} !== 67'd0) begin
            fails++;
            $display("FAIL abort_outputs_zero: got %h want 0", {b2.if_ack, b2.d_ack, b2.busy, b2.if_rdata, b2.d_rdata});
        end
        b2.d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_drd = 32'd0; exp_ird = 32'd0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (b2.d_ack || b2.if_ack) acks++;
        end
        tests++;
        if (acks !== 0) begin fails++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
        op2(1'b0, 1'b0, 10'd7, 32'd0, rd, lat, bc);
        exp_drd = 32'h1234_5678;
        tests++;
        if (rd !== exp_drd) begin fails++; $display("FAIL abort_mem_kept: got %h want %h", rd, exp_drd); end
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL abort_post_lat: got %0d want 4", lat); end
    endtask

    task automatic test_random();
        logic [31:0] refm [16];
        logic [9:0]  base;
        int          kind, idx, bad_lat;
        bad_lat = 0;
        base = 10'($urandom_range(16, 1000));
        for (int i = 0; i < 16; i++) begin
            refm[i] = $urandom;
            op2(1'b0, 1'b1, base + 10'(i), refm[i], rd, lat, bc);
            if (lat != 4) bad_lat++;
        end
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 2);
            idx  = $urandom_range(0, 15);
            if (kind == 0) begin
                refm[idx] = $urandom;
                op2(1'b0, 1'b1, base + 10'(idx), refm[idx], rd, lat, bc);
                tests++;
                if (rd !== exp_drd) begin fails++; $display("FAIL rand_store_drdata[%0d]: got %h want %h", i, rd, exp_drd); end
            end else if (kind == 1) begin
                op2(1'b0, 1'b0, base + 10'(idx), 32'd0, rd, lat, bc);
                exp_drd = refm[idx];
                tests++;
                if (rd !== exp_drd) begin fails++; $display("FAIL rand_load[%0d]: got %h want %h", i, rd, exp_drd); end
            end else begin
                op2(1'b1, 1'b0, base + 10'(idx), 32'd0, rd, lat, bc);
                exp_ird = refm[idx];
                tests++;
                if (rd !== exp_ird) begin fails++; $display("FAIL rand_fetch[%0d]: got %h want %h", i, rd, exp_ird); end
            end
            if (lat != 4) bad_lat++;
        end
        tests++;
        if (bad_lat !== 0) begin fails++; $display("FAIL rand_latency: got %0d bad, want 0", bad_lat); end
    endtask

    task automatic test_wait0();
        int n, last, cyc;
        bit gap_bad, data_bad;
        op0(1'b1, 10'h3FF, 32'hDEAD_BEEF, rd, lat);
        tests++;
        if (lat !== 2) begin fails++; $display("FAIL w0_store_lat: got %0d want 2", lat); end
        op0(1'b0, 10'h3FF, 32'd0, rd, lat);
        tests++;
        if (lat !== 2) begin fails++; $display("FAIL w0_load_lat: got %0d want 2", lat); end
        tests++;
        if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL w0_load_data: got %h want deadbeef", rd); end
        n = 0; last = 0; cyc = 0; gap_bad = 0; data_bad = 0;
        @(posedge clk); #1;
        b0.d_req = 1'b1; b0.d_we = 1'b0; b0.d_addr = 10'h3FF;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (b0.d_ack) begin
                if (n > 0 && cyc - last != 2) gap_bad = 1;
                if (b0.d_rdata !== 32'hDEAD_BEEF) data_bad = 1;
                last = cyc;
                n++;
            end
        end
        b0.d_req = 1'b0;
        tests++;
        if (n !== 4 || gap_bad !== 1'b0) begin
            fails++; $display("FAIL w0_back_to_back: got %0d acks gap_bad=%0d want 4 acks every 2", n, gap_bad);
        end
        tests++;
        if (data_bad !== 1'b0) begin fails++; $display("FAIL w0_b2b_data: got wrong data want deadbeef"); end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0;
        b2.if_req = 0; b2.if_addr = '0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = '0; b2.d_wdata = '0;
        b0.if_req = 0; b0.if_addr = '0; b0.d_req = 0; b0.d_we = 0; b0.d_addr = '0; b0.d_wdata = '0;
        test_reset();
        test_basic();
        test_arbitration();
        test_midwait_change();
        test_reset_abort();
        test_random();
        test_wait0();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
